ps2_rx: RTL and testbench

PS/2 device-to-host frame receiver feeding `ps2_converter`. Synchronizes and debounces the raw `ps2_clk`/`ps2_data` lines, shifts in 11-bit frames on debounced clock falling edges, and validates start, stop and parity. It presents the scan code on `ps2_code` and raises the `ps2_code_new` level once the bus has been idle long enough to end the frame. The converter's rising-edge detector consumes this level directly.

---
 rtl/ps2_rx.sv | 156 +++++++++++++++
 tb/tb_ps2_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: sync + debounce, 11-bit shift, start/stop/parity check.
// Define PS2_RX_PARITY_CHECK_EN to make odd parity part of frame validity.
module ps2_rx #(
  parameter int unsigned clk_freq              = 50_000_000,
  parameter int unsigned debounce_counter_size = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_code,
  output logic       ps2_code_new,
  output logic       frame_err
);

  localparam int unsigned IdleCycles = clk_freq / 18000;
  localparam int unsigned IdleW      = $clog2(IdleCycles + 1);
  localparam int unsigned DbW        = debounce_counter_size;
  localparam logic [DbW-1:0] DbMax   = '1;

  typedef enum logic {StIdle, StRecv} state_e;

  state_e state_q, state_d;

  // Index 0 carries ps2_clk, index 1 carries ps2_data.
  logic [1:0]     sync1_q, sync2_q, deb_q;
  logic [DbW-1:0] db_cnt_q [2];

  logic             clk_deb_prev_q;
  logic [IdleW-1:0] idle_cnt_q;
  logic [10:0]      shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       code_q, code_d;
  logic             code_new_q, code_new_d;
  logic             frame_err_q, frame_err_d;

  logic fall, idle_hit, parity_ok, frame_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      deb_q       <= '1;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q <= {ps2_data, ps2_clk};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync1_q[i] != sync2_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] != DbMax) begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end else begin
          deb_q[i] <= sync2_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_deb_prev_q <= 1'b1;
      idle_cnt_q     <= '0;
    end else begin
      clk_deb_prev_q <= deb_q[0];
      if (!deb_q[0]) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != IdleW'(IdleCycles)) begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end
    end
  end

  assign fall     = clk_deb_prev_q & ~deb_q[0];
  // True on the cycle whose edge brings the idle count up to IdleCycles.
  assign idle_hit = deb_q[0] && (idle_cnt_q == IdleW'(IdleCycles - 1));

`ifdef PS2_RX_PARITY_CHECK_EN
  assign parity_ok = ^shift_q[9:1];
`else
  assign parity_ok = 1'b1;
`endif

  assign frame_ok = (bit_cnt_q == 4'd11) && !shift_q[0] && shift_q[10] && parity_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (fall) state_d = StRecv;
      StRecv: if (idle_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    code_d      = code_q;
    code_new_d  = code_new_q;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        bit_cnt_d = 4'd0;
        if (fall) begin
          shift_d    = {deb_q[1], shift_q[10:1]};
          bit_cnt_d  = 4'd1;
          code_new_d = 1'b0;
        end
      end
      StRecv: begin
        if (fall) begin
          shift_d = {deb_q[1], shift_q[10:1]};
          if (bit_cnt_q != 4'd12) bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (idle_hit) begin
          if (frame_ok) begin
            code_d     = shift_q[8:1];
            code_new_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      code_q      <= 8'h00;
      code_new_q  <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      code_q      <= code_d;
      code_new_q  <= code_new_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ps2_code     = code_q;
  assign ps2_code_new = code_new_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: table of PS/2 frames with a scoreboard of expected results.
// Clock rate and debounce width are scaled down so every frame fits a short run.
module tb_ps2_rx;

  localparam int unsigned ClkFreq = 1_800_000;  // idle threshold of 100 cycles
  localparam int unsigned DbN     = 4;
  localparam int Idle    = ClkFreq / 18000;
  localparam int RiseLat = Idle + (1 << DbN) + 2;
  localparam int Half    = 50;

`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit ParityChk = 1'b1;
`else
  localparam bit ParityChk = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2_code;
  logic       ps2_code_new;
  logic       frame_err;

  ps2_rx #(
    .clk_freq             (ClkFreq),
    .debounce_counter_size(DbN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_code    (ps2_code),
    .ps2_code_new(ps2_code_new),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    bit         par_flip;
    bit         stop;
    int         nbits;
    bit         idle_glitch;
    int         mid_glitch;
    bit         exp_valid;
  } vec_t;

  typedef struct {
    bit         err;
    logic [7:0] code;
  } exp_t;

  exp_t       sbq[$];
  vec_t       vecs[10];
  int         n_vec = 0;
  int         n_miss = 0;
  int         last_rise = 0;
  bit         mon_en = 1'b0;
  logic       new_prev = 1'b1;
  logic       err_prev = 1'b0;
  logic [7:0] model_code = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic on_event(input bit is_err);
    exp_t e;
    check(is_err ? "err_has_expectation" : "new_has_expectation", 32'(sbq.size() != 0), 1);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    if (is_err) begin
      check("err_expected", 32'(e.err), 1);
      check("code_held_on_err", ps2_code, e.code);
      check("new_low_on_err", ps2_code_new, 0);
    end else begin
      check("new_expected_valid", 32'(e.err), 0);
      check("code_on_new", ps2_code, e.code);
      check("new_rise_latency", cyc - last_rise, RiseLat);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ps2_code_new && !new_prev) on_event(1'b0);
      if (frame_err) begin
        check("err_pulse_width", err_prev, 0);
        if (!err_prev) on_event(1'b1);
      end
    end
    new_prev <= ps2_code_new;
    err_prev <= frame_err;
  end

  // Data changes mid-high; abort_after > 0 stops during the low phase of that bit.
  task automatic send_frame(input vec_t v, input int abort_after);
    logic [11:0] bits;
    bits = {1'b1, v.stop, (~^v.data) ^ v.par_flip, v.data, 1'b0};
    if (v.idle_glitch) begin
      ps2_clk = 1'b0;
      repeat (8) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (40) @(negedge clk);
    end
    for (int i = 0; i < v.nbits; i++) begin
      ps2_data = bits[i];
      if (i == v.mid_glitch) begin
        repeat (8) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (9) @(negedge clk);
      end else begin
        repeat (Half / 2) @(negedge clk);
      end
      ps2_clk = 1'b0;
      repeat (Half) @(negedge clk);
      if (i == 0 && mon_en) check("new_low_in_frame", ps2_code_new, 0);
      if (i + 1 == abort_after) return;
      ps2_clk   = 1'b1;
      last_rise = cyc;
      repeat (Half / 2) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic expect_frame(input vec_t v);
    exp_t e;
    if (v.exp_valid) model_code = v.data;
    e.err  = !v.exp_valid;
    e.code = model_code;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0) begin
      check("result_timeout", sbq.size(), 0);
      sbq.delete();
    end
    repeat (30) @(negedge clk);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{8'h1C, 0, 1, 11, 0, -1, 1};
    vecs[1] = '{8'hF0, 0, 1, 11, 0, -1, 1};
    vecs[2] = '{8'h1C, 0, 1, 11, 0, -1, 1};
    vecs[3] = '{8'h1C, 1, 1, 11, 0, -1, !ParityChk};
    vecs[4] = '{8'h1C, 0, 1, 10, 0, -1, 0};
    vecs[5] = '{8'h55, 0, 0, 11, 0, -1, 0};
    vecs[6] = '{8'h29, 0, 1, 11, 1, 3, 1};
    vecs[7] = '{8'h00, 0, 1, 11, 0, -1, 1};
    vecs[8] = '{8'h33, 0, 1, 12, 0, -1, 0};
    vecs[9] = '{8'hFF, 0, 1, 11, 0, -1, 1};

    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_code", ps2_code, 8'h00);
    check("reset_new", ps2_code_new, 1);
    check("reset_err", frame_err, 0);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      expect_frame(vecs[i]);
      send_frame(vecs[i], 0);
      drain();
    end

    // Reset after the fifth bit of a frame; the partial frame must vanish.
    v = '{8'h5A, 0, 1, 11, 0, -1, 1};
    send_frame(v, 5);
    mon_en   = 1'b0;
    rst      = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_code", ps2_code, 8'h00);
    check("midreset_new", ps2_code_new, 1);
    check("midreset_err", frame_err, 0);
    rst = 1'b1;
    model_code = 8'h00;
    repeat (200) @(negedge clk);
    check("no_err_after_reset", frame_err, 0);
    mon_en = 1'b1;
    expect_frame(v);
    send_frame(v, 0);
    drain();
    check("final_code", ps2_code, 8'h5A);
    check("final_new", ps2_code_new, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule
